// File: rtl/inst_fetch_pkg.sv
// Shared bus widths, reset level and fetch FSM encodings for the IF stage.
package inst_fetch_pkg;
    localparam int InstAddrBus = 32;
    localparam int InstBus     = 32;
    localparam logic RstEnable = 1'b1;

    localparam logic [0:0] ST_REQ  = 1'b0;
    localparam logic [0:0] ST_WAIT = 1'b1;

    function automatic logic [InstAddrBus-1:0] word_align(input logic [InstAddrBus-1:0] a);
        return a & 32'hFFFF_FFFC;
    endfunction
endpackage

// File: rtl/inst_fetch_if.sv
// Instruction memory request/response bus between fetch (master) and imem (slave).
interface inst_fetch_if;
    import inst_fetch_pkg::*;

    logic                   imem_req_o;
    logic [InstAddrBus-1:0] imem_addr_o;
    logic                   imem_gnt_i;
    logic                   imem_rvalid_i;
    logic [InstBus-1:0]     imem_rdata_i;

    modport master (
        output imem_req_o, imem_addr_o,
        input  imem_gnt_i, imem_rvalid_i, imem_rdata_i
    );

    modport slave (
        input  imem_req_o, imem_addr_o,
        output imem_gnt_i, imem_rvalid_i, imem_rdata_i
    );
endinterface

// File: rtl/inst_fetch_pc_reg.sv
// Fetch PC register: reset value, sequential +4 on grant, or redirect target.
module pc_reg
    import inst_fetch_pkg::*;
#(
    parameter logic [InstAddrBus-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   adv_i,
    input  logic                   branch_i,
    input  logic [InstAddrBus-1:0] target_i,
    output logic [InstAddrBus-1:0] pc_o
);
    logic [InstAddrBus-1:0] pc_q, pc_d;

    // A redirect wins over a granted advance; the granted address is already captured upstream.
    always_comb begin
        pc_d = pc_q;
        if (branch_i)   pc_d = word_align(target_i);
        else if (adv_i) pc_d = pc_q + 32'd4;
    end

    always_ff @(posedge clk) begin
        if (rst == RstEnable) pc_q <= word_align(RESET_PC);
        else                  pc_q <= pc_d;
    end

    assign pc_o = pc_q;
endmodule

// File: rtl/inst_fetch.sv
// IF stage: single-outstanding imem fetch FSM feeding a one-entry output slot.
module inst_fetch
    import inst_fetch_pkg::*;
#(
    parameter logic [InstAddrBus-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   stall_i,
    input  logic                   branch_flag_i,
    input  logic [InstAddrBus-1:0] branch_target_i,
    inst_fetch_if.master           imem,
    output logic [InstAddrBus-1:0] if_pc_o,
    output logic [InstBus-1:0]     if_inst_o,
    output logic                   if_valid_o
);
    logic [0:0]             state_q, state_d;
    logic                   kill_q, kill_d;
    logic [InstAddrBus-1:0] fl_addr_q, fl_addr_d;
    logic [InstAddrBus-1:0] if_pc_q, if_pc_d;
    logic [InstBus-1:0]     if_inst_q, if_inst_d;
    logic                   if_valid_q, if_valid_d;
    logic [InstAddrBus-1:0] pc;
    logic                   req, gnt_fire, rsp, load, xfer;

    pc_reg #(.RESET_PC(RESET_PC)) u_pc_reg (
        .clk      (clk),
        .rst      (rst),
        .adv_i    (gnt_fire),
        .branch_i (branch_flag_i),
        .target_i (branch_target_i),
        .pc_o     (pc)
    );

    // Only request when the slot will be empty by the time the response lands.
    assign req      = (rst != RstEnable) && (state_q == ST_REQ) && (!if_valid_q || !stall_i);
    assign gnt_fire = req && imem.imem_gnt_i;
    assign rsp      = (state_q == ST_WAIT) && imem.imem_rvalid_i;
    assign load     = rsp && !kill_q && !branch_flag_i;
    assign xfer     = if_valid_q && !stall_i && !branch_flag_i;

    assign imem.imem_req_o  = req;
    assign imem.imem_addr_o = pc;

    always_comb begin
        state_d   = state_q;
        kill_d    = kill_q;
        fl_addr_d = fl_addr_q;
        case (state_q)
            ST_REQ: begin
                if (gnt_fire) begin
                    state_d   = ST_WAIT;
                    fl_addr_d = pc;
                    kill_d    = branch_flag_i;
                end
            end
            ST_WAIT: begin
                if (rsp) begin
                    state_d = ST_REQ;
                    kill_d  = 1'b0;
                end else if (branch_flag_i) begin
                    kill_d  = 1'b1;
                end
            end
            default: state_d = ST_REQ;
        endcase
    end

    always_comb begin
        if_valid_d = if_valid_q;
        if_pc_d    = if_pc_q;
        if_inst_d  = if_inst_q;
        if (xfer) if_valid_d = 1'b0;
        if (load) begin
            if_valid_d = 1'b1;
            if_pc_d    = fl_addr_q;
            if_inst_d  = imem.imem_rdata_i;
        end
        if (branch_flag_i) if_valid_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            state_q    <= ST_REQ;
            kill_q     <= 1'b0;
            fl_addr_q  <= '0;
            if_pc_q    <= '0;
            if_inst_q  <= '0;
            if_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            kill_q     <= kill_d;
            fl_addr_q  <= fl_addr_d;
            if_pc_q    <= if_pc_d;
            if_inst_q  <= if_inst_d;
            if_valid_q <= if_valid_d;
        end
    end

    assign if_pc_o    = if_pc_q;
    assign if_inst_o  = if_inst_q;
    assign if_valid_o = if_valid_q;
endmodule

// File: tb/tb_inst_fetch.sv
// Directed scenario bench for inst_fetch with a small latency-programmable imem model.
module tb_inst_fetch;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall_i = 1'b0;
    logic        branch_flag_i = 1'b0;
    logic [31:0] branch_target_i = 32'h0;
    logic [31:0] if_pc_o, if_inst_o;
    logic        if_valid_o;

    logic        gnt_en = 1'b1;
    int          lat = 1;
    logic        mem_rvalid = 1'b0;
    logic [31:0] mem_rdata = 32'h0;
    logic        pend = 1'b0;
    int          cnt = 0;
    logic [31:0] paddr = 32'h0;

    int checks = 0;
    int errors = 0;

    inst_fetch_if bus();

    inst_fetch dut (
        .clk             (clk),
        .rst             (rst),
        .stall_i         (stall_i),
        .branch_flag_i   (branch_flag_i),
        .branch_target_i (branch_target_i),
        .imem            (bus.master),
        .if_pc_o         (if_pc_o),
        .if_inst_o       (if_inst_o),
        .if_valid_o      (if_valid_o)
    );

    always #5 clk = ~clk;

    assign bus.imem_gnt_i    = gnt_en;
    assign bus.imem_rvalid_i = mem_rvalid;
    assign bus.imem_rdata_i  = mem_rdata;

    // Memory answers with ~addr, `lat` cycles after the grant; reset drops anything in flight.
    always @(posedge clk) begin
        if (rst) begin
            pend       <= 1'b0;
            mem_rvalid <= 1'b0;
        end else begin
            mem_rvalid <= 1'b0;
            if (pend) begin
                if (cnt == 1) begin
                    mem_rvalid <= 1'b1;
                    mem_rdata  <= ~paddr;
                    pend       <= 1'b0;
                end else cnt <= cnt - 1;
            end
            if (bus.imem_req_o && gnt_en) begin
                if (lat == 1) begin
                    mem_rvalid <= 1'b1;
                    mem_rdata  <= ~bus.imem_addr_o;
                end else begin
                    pend  <= 1'b1;
                    cnt   <= lat - 1;
                    paddr <= bus.imem_addr_o;
                end
            end
        end
    end

    task automatic nxt;
        @(negedge clk);
    endtask

    task automatic test_reset;
        repeat (3) nxt();
        checks++; if (if_valid_o !== 1'b0) begin errors++; $display("FAIL rst_valid got %b want 0", if_valid_o); end
        checks++; if (if_pc_o !== 32'h0) begin errors++; $display("FAIL rst_pc got %h want 0", if_pc_o); end
        checks++; if (if_inst_o !== 32'h0) begin errors++; $display("FAIL rst_inst got %h want 0", if_inst_o); end
        checks++; if (bus.imem_req_o !== 1'b0) begin errors++; $display("FAIL rst_req got %b want 0", bus.imem_req_o); end
    endtask

    task automatic test_zero_wait;
        logic [31:0] epc;
        rst = 1'b0;
        #1;
        checks++; if (bus.imem_req_o !== 1'b1) begin errors++; $display("FAIL first_req got %b want 1", bus.imem_req_o); end
        checks++; if (bus.imem_addr_o !== 32'h0) begin errors++; $display("FAIL first_addr got %h want 0", bus.imem_addr_o); end
        for (int k = 1; k <= 6; k++) begin
            nxt();
            checks++; if (if_valid_o !== (k % 2 == 0)) begin errors++; $display("FAIL zw_valid c%0d got %b want %b", k, if_valid_o, (k % 2 == 0)); end
            if (k % 2 == 0) begin
                epc = (k - 2) * 2;
                checks++; if (if_pc_o !== epc) begin errors++; $display("FAIL zw_pc c%0d got %h want %h", k, if_pc_o, epc); end
                checks++; if (if_inst_o !== ~epc) begin errors++; $display("FAIL zw_inst c%0d got %h want %h", k, if_inst_o, ~epc); end
            end
        end
    endtask

    task automatic test_stall;
        stall_i = 1'b1;
        #1;
        checks++; if (bus.imem_req_o !== 1'b0) begin errors++; $display("FAIL stall_req0 got %b want 0", bus.imem_req_o); end
        for (int k = 0; k < 3; k++) begin
            nxt();
            checks++; if (if_valid_o !== 1'b1) begin errors++; $display("FAIL stall_valid %0d got %b want 1", k, if_valid_o); end
            checks++; if (if_pc_o !== 32'h8) begin errors++; $display("FAIL stall_pc %0d got %h want 8", k, if_pc_o); end
            checks++; if (if_inst_o !== ~32'h8) begin errors++; $display("FAIL stall_inst %0d got %h want %h", k, if_inst_o, ~32'h8); end
            checks++; if (bus.imem_req_o !== 1'b0) begin errors++; $display("FAIL stall_req %0d got %b want 0", k, bus.imem_req_o); end
        end
        stall_i = 1'b0;
        #1;
        checks++; if (bus.imem_req_o !== 1'b1 || bus.imem_addr_o !== 32'hC) begin errors++; $display("FAIL stall_resume req=%b addr=%h want 1/c", bus.imem_req_o, bus.imem_addr_o); end
        nxt();
        checks++; if (if_valid_o !== 1'b0) begin errors++; $display("FAIL stall_xfer got %b want 0", if_valid_o); end
        nxt();
        checks++; if (if_valid_o !== 1'b1 || if_pc_o !== 32'hC) begin errors++; $display("FAIL stall_next v=%b pc=%h want 1/c", if_valid_o, if_pc_o); end
    endtask

    task automatic test_branch_wait;
        lat = 3;
        nxt();
        checks++; if (bus.imem_req_o !== 1'b0) begin errors++; $display("FAIL bw_wait_req got %b want 0", bus.imem_req_o); end
        branch_flag_i = 1'b1; branch_target_i = 32'h100;
        nxt();
        branch_flag_i = 1'b0; lat = 1;
        checks++; if (if_valid_o !== 1'b0 || bus.imem_req_o !== 1'b0) begin errors++; $display("FAIL bw_hold v=%b req=%b want 0/0", if_valid_o, bus.imem_req_o); end
        nxt();
        checks++; if (if_valid_o !== 1'b0) begin errors++; $display("FAIL bw_rsp_cycle got %b want 0", if_valid_o); end
        nxt();
        checks++; if (if_valid_o !== 1'b0) begin errors++; $display("FAIL bw_dropped got %b want 0", if_valid_o); end
        checks++; if (bus.imem_req_o !== 1'b1 || bus.imem_addr_o !== 32'h100) begin errors++; $display("FAIL bw_req req=%b addr=%h want 1/100", bus.imem_req_o, bus.imem_addr_o); end
        repeat (2) nxt();
        checks++; if (if_valid_o !== 1'b1 || if_pc_o !== 32'h100 || if_inst_o !== ~32'h100) begin errors++; $display("FAIL bw_slot v=%b pc=%h inst=%h want 1/100/%h", if_valid_o, if_pc_o, if_inst_o, ~32'h100); end
    endtask

    task automatic test_branch_rvalid;
        nxt();
        checks++; if (if_valid_o !== 1'b0 || mem_rvalid !== 1'b1) begin errors++; $display("FAIL br_setup v=%b rvalid=%b want 0/1", if_valid_o, mem_rvalid); end
        branch_flag_i = 1'b1; branch_target_i = 32'h200;
        nxt();
        branch_flag_i = 1'b0;
        checks++; if (if_valid_o !== 1'b0) begin errors++; $display("FAIL br_noload got %b want 0", if_valid_o); end
        checks++; if (bus.imem_req_o !== 1'b1 || bus.imem_addr_o !== 32'h200) begin errors++; $display("FAIL br_req req=%b addr=%h want 1/200", bus.imem_req_o, bus.imem_addr_o); end
        repeat (2) nxt();
        checks++; if (if_valid_o !== 1'b1 || if_pc_o !== 32'h200) begin errors++; $display("FAIL br_slot v=%b pc=%h want 1/200", if_valid_o, if_pc_o); end
    endtask

    task automatic test_branch_gnt;
        branch_flag_i = 1'b1; branch_target_i = 32'h203;
        #1;
        checks++; if (bus.imem_req_o !== 1'b1 || bus.imem_addr_o !== 32'h204) begin errors++; $display("FAIL bg_req req=%b addr=%h want 1/204", bus.imem_req_o, bus.imem_addr_o); end
        nxt();
        branch_flag_i = 1'b0;
        checks++; if (if_valid_o !== 1'b0 || bus.imem_req_o !== 1'b0) begin errors++; $display("FAIL bg_kill v=%b req=%b want 0/0", if_valid_o, bus.imem_req_o); end
        nxt();
        checks++; if (if_valid_o !== 1'b0) begin errors++; $display("FAIL bg_noload got %b want 0", if_valid_o); end
        checks++; if (bus.imem_req_o !== 1'b1 || bus.imem_addr_o !== 32'h200) begin errors++; $display("FAIL bg_refetch req=%b addr=%h want 1/200", bus.imem_req_o, bus.imem_addr_o); end
        repeat (2) nxt();
        checks++; if (if_valid_o !== 1'b1 || if_pc_o !== 32'h200 || if_inst_o !== ~32'h200) begin errors++; $display("FAIL bg_slot v=%b pc=%h inst=%h want 1/200/%h", if_valid_o, if_pc_o, if_inst_o, ~32'h200); end
    endtask

    task automatic test_wrap;
        gnt_en = 1'b0;
        branch_flag_i = 1'b1; branch_target_i = 32'hFFFF_FFFC;
        nxt();
        branch_flag_i = 1'b0;
        checks++; if (if_valid_o !== 1'b0) begin errors++; $display("FAIL wr_clear got %b want 0", if_valid_o); end
        checks++; if (bus.imem_req_o !== 1'b1 || bus.imem_addr_o !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wr_ungnt req=%b addr=%h want 1/fffffffc", bus.imem_req_o, bus.imem_addr_o); end
        gnt_en = 1'b1;
        repeat (2) nxt();
        checks++; if (if_valid_o !== 1'b1 || if_pc_o !== 32'hFFFF_FFFC || if_inst_o !== 32'h3) begin errors++; $display("FAIL wr_slot v=%b pc=%h inst=%h want 1/fffffffc/3", if_valid_o, if_pc_o, if_inst_o); end
        checks++; if (bus.imem_req_o !== 1'b1 || bus.imem_addr_o !== 32'h0) begin errors++; $display("FAIL wr_addr req=%b addr=%h want 1/0", bus.imem_req_o, bus.imem_addr_o); end
    endtask

    task automatic test_reset_mid_wait;
        nxt();
        checks++; if (bus.imem_req_o !== 1'b0) begin errors++; $display("FAIL rm_wait got %b want 0", bus.imem_req_o); end
        rst = 1'b1;
        nxt();
        checks++; if (if_valid_o !== 1'b0 || if_pc_o !== 32'h0 || if_inst_o !== 32'h0) begin errors++; $display("FAIL rm_zero v=%b pc=%h inst=%h want 0/0/0", if_valid_o, if_pc_o, if_inst_o); end
        checks++; if (bus.imem_req_o !== 1'b0) begin errors++; $display("FAIL rm_req got %b want 0", bus.imem_req_o); end
        nxt();
        rst = 1'b0;
        #1;
        checks++; if (bus.imem_req_o !== 1'b1 || bus.imem_addr_o !== 32'h0) begin errors++; $display("FAIL rm_restart req=%b addr=%h want 1/0", bus.imem_req_o, bus.imem_addr_o); end
        repeat (2) nxt();
        checks++; if (if_valid_o !== 1'b1 || if_pc_o !== 32'h0 || if_inst_o !== 32'hFFFF_FFFF) begin errors++; $display("FAIL rm_slot v=%b pc=%h inst=%h want 1/0/ffffffff", if_valid_o, if_pc_o, if_inst_o); end
    endtask

    initial begin
        test_reset();
        test_zero_wait();
        test_stall();
        test_branch_wait();
        test_branch_rvalid();
        test_branch_gnt();
        test_wrap();
        test_reset_mid_wait();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end
endmodule
